// File: rtl/rf_access_arbiter_if.sv
// rf_access_arbiter_if
// Bundles the two requester channels, the clear/busy control pair and the
// register-file side of rf_access_arbiter.
//   Channel n (n = 0,1): reqN, weN, addrN, wdataN in; ackN, rdataN, rvalidN out.
//   Control            : clr in, busy out.
//   Register file      : rf_we, rf_addr, rf_wdata out; rf_rdata in.
// The "slave" modport is the arbiter's view. The "master" modport is the view
// of the surrounding datapath and register file.
interface rf_access_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          clr;
    logic          busy;

    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          rvalid0;
    logic          rvalid1;

    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    modport slave (
        input  clr, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_rdata,
        output busy, ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
               rf_we, rf_addr, rf_wdata
    );

    modport master (
        output clr, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_rdata,
        input  busy, ack0, ack1, rdata0, rdata1, rvalid0, rvalid1,
               rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
// Shares the single address/write port of a 2**AW x DW register file between
// two requesters using round-robin arbitration. Read data comes back one
// cycle after the grant. After reset, or on a clr pulse, it runs a sweep that
// writes zero to every entry before it accepts any access.
// Ports:
//   clk   : single clock. All state changes on the rising edge.
//   reset : synchronous, active-high.
//   bus   : rf_access_arbiter_if.slave. Holds the requester channels, clr/busy,
//           and the register-file write/address/data port.
module rf_access_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rf_access_arbiter_if.slave    bus
);

    typedef enum logic {
        ST_CLR,
        ST_RUN
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          last_q;      // channel granted most recently
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;

    logic          run;
    logic          grant0;
    logic          grant1;

    // Round robin: a lone requester always wins. On a tie, the channel that
    // did not win last time gets the grant.
    always_comb begin
        run    = (state_q == ST_RUN);
        grant0 = run && bus.req0 && (!bus.req1 || last_q);
        grant1 = run && bus.req1 && (!bus.req0 || !last_q);
    end

    // Register-file port. The sweep drives the counter address with zero data.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_addr  = '0;
        bus.rf_wdata = '0;
        if (!run) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = cnt_q;
        end else if (grant0) begin
            bus.rf_we    = bus.we0;
            bus.rf_addr  = bus.addr0;
            bus.rf_wdata = bus.wdata0;
        end else if (grant1) begin
            bus.rf_we    = bus.we1;
            bus.rf_addr  = bus.addr1;
            bus.rf_wdata = bus.wdata1;
        end
    end

    assign bus.ack0    = grant0;
    assign bus.ack1    = grant1;
    assign bus.busy    = !run;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLR;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;

            case (state_q)
                ST_CLR: begin
                    // A clr pulse during the sweep is ignored, so the sweep
                    // always finishes on the original schedule.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.clr) begin
                        state_q <= ST_CLR;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ST_CLR;
            endcase

            // A grant made in the same cycle as clr still completes.
            if (grant0) begin
                last_q <= 1'b0;
                if (!bus.we0) begin
                    rdata0_q  <= bus.rf_rdata;
                    rvalid0_q <= 1'b1;
                end
            end else if (grant1) begin
                last_q <= 1'b1;
                if (!bus.we1) begin
                    rdata1_q  <= bus.rf_rdata;
                    rvalid1_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
module tb_rf_access_arbiter;
    localparam int AW = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    rf_access_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file model. It fills with 0xFF during reset so that the sweep
    // visibly has to zero it.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 8'hFF;
        end else if (bus.rf_we) begin
            mem[bus.rf_addr] <= bus.rf_wdata;
        end
    end
    assign bus.rf_rdata = mem[bus.rf_addr];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int n0, n1;
    logic exp0;

    initial begin
        reset = 1'b1;
        bus.clr = 0; bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        tick(); tick();

        // Reset values
        chk("rst_busy", bus.busy, 1);
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rvalid1", bus.rvalid1, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        reset = 1'b0;

        // Initial sweep: 8 cycles writing zero to addresses 0..7
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("sweep_busy", bus.busy, 1);
            chk("sweep_we", bus.rf_we, 1);
            chk("sweep_addr", bus.rf_addr, i);
            chk("sweep_wdata", bus.rf_wdata, 0);
            tick();
        end
        settle();
        chk("sweep_done_busy", bus.busy, 0);

        // Read every address back: all zero
        for (int a = 0; a < 8; a++) begin
            bus.req0 = 1; bus.we0 = 0; bus.addr0 = AW'(a);
            settle();
            chk("rd_all_ack0", bus.ack0, 1);
            tick();
            chk("rd_all_rvalid0", bus.rvalid0, 1);
            chk("rd_all_rdata0", bus.rdata0, 0);
        end
        bus.req0 = 0;
        settle();
        tick();
        chk("idle_rvalid0", bus.rvalid0, 0);

        // Channel 0 writes 0xA5 to address 3, then reads it back
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3; bus.wdata0 = 8'hA5;
        settle();
        chk("wr_ack0", bus.ack0, 1);
        chk("wr_rf_we", bus.rf_we, 1);
        chk("wr_rf_addr", bus.rf_addr, 3);
        chk("wr_rf_wdata", bus.rf_wdata, 8'hA5);
        tick();
        chk("wr_rvalid0", bus.rvalid0, 0);
        chk("wr_rdata0_hold", bus.rdata0, 0);
        bus.we0 = 0;
        settle();
        chk("rd_ack0", bus.ack0, 1);
        chk("rd_rf_we", bus.rf_we, 0);
        tick();
        chk("rd_rvalid0", bus.rvalid0, 1);
        chk("rd_rdata0", bus.rdata0, 8'hA5);
        bus.req0 = 0;

        // Preload: ch0 writes 0x11 to addr 1, ch1 writes 0x22 to addr 2
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 1; bus.wdata0 = 8'h11;
        settle();
        chk("pre_ack0", bus.ack0, 1);
        tick();
        bus.req0 = 0;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 2; bus.wdata1 = 8'h22;
        settle();
        chk("pre_ack1", bus.ack1, 1);
        tick();
        bus.req1 = 0;

        // Contention: both read for 4 cycles. The last grant was ch1, so ch0 goes first.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 1;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            exp0 = ((k % 2) == 0);
            settle();
            chk("rr_ack0", bus.ack0, exp0);
            chk("rr_ack1", bus.ack1, !exp0);
            chk("rr_ack_excl", bus.ack0 & bus.ack1, 0);
            tick();
            chk("rr_rvalid0", bus.rvalid0, exp0);
            chk("rr_rvalid1", bus.rvalid1, !exp0);
            if (bus.rvalid0) n0++;
            if (bus.rvalid1) n1++;
            if (exp0) chk("rr_rdata0", bus.rdata0, 8'h11);
            else      chk("rr_rdata1", bus.rdata1, 8'h22);
            if (k == 3) begin
                bus.req0 = 0; bus.req1 = 0;
            end
        end
        tick();
        chk("rr_tail_rvalid0", bus.rvalid0, 0);
        chk("rr_tail_rvalid1", bus.rvalid1, 0);
        chk("rr_count0", n0, 2);
        chk("rr_count1", n1, 2);

        // clr pulsed while ch1 is granted a write of 0x3C to address 5
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5; bus.wdata1 = 8'h3C; bus.clr = 1;
        settle();
        chk("clr_ack1", bus.ack1, 1);
        chk("clr_rf_addr", bus.rf_addr, 5);
        chk("clr_rf_wdata", bus.rf_wdata, 8'h3C);
        tick();
        bus.clr = 0; bus.req1 = 0;
        chk("clr_write_done", mem[5], 8'h3C);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("clr_sweep_busy", bus.busy, 1);
            chk("clr_sweep_ack0", bus.ack0, 0);
            chk("clr_sweep_ack1", bus.ack1, 0);
            chk("clr_sweep_addr", bus.rf_addr, i);
            tick();
        end
        settle();
        chk("clr_after_ack0", bus.ack0, 1);
        tick();
        chk("clr_after_rvalid0", bus.rvalid0, 1);
        chk("clr_after_rdata0", bus.rdata0, 0);
        bus.req0 = 0;

        // Reset asserted at sweep cycle 5 with req0 high
        bus.clr = 1;
        settle();
        tick();
        bus.clr = 0;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("rst5_addr", bus.rf_addr, i);
            chk("rst5_ack0", bus.ack0, 0);
            if (i == 5) reset = 1;
            tick();
        end
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("rst5_re_busy", bus.busy, 1);
            chk("rst5_re_addr", bus.rf_addr, i);
            chk("rst5_re_ack0", bus.ack0, 0);
            tick();
        end
        settle();
        chk("rst5_grant_ack0", bus.ack0, 1);
        // Reset in the grant cycle must cancel the pending rvalid
        reset = 1;
        tick();
        reset = 0;
        chk("rst_cancel_rvalid0", bus.rvalid0, 0);
        chk("rst_cancel_busy", bus.busy, 1);
        bus.req0 = 0;

        // clr pulsed at sweep cycle 3: the sweep is not restarted
        for (int i = 0; i < 8; i++) begin
            bus.clr = (i == 3);
            settle();
            chk("clr3_busy", bus.busy, 1);
            chk("clr3_addr", bus.rf_addr, i);
            tick();
        end
        bus.clr = 0;
        settle();
        chk("clr3_done_busy", bus.busy, 0);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3;
        settle();
        chk("final_ack0", bus.ack0, 1);
        tick();
        chk("final_rvalid0", bus.rvalid0, 1);
        chk("final_rdata0", bus.rdata0, 0);
        bus.req0 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
